parallel_port_ctrl: RTL

//  Avalon-MM slave that owns the 8-bit bidirectional parallel port and sequences it. Nios writes

---
 rtl/parallel_port_pkg.sv | 26 ++
 rtl/parallel_port_ctrl_prescaler.sv | 31 +++
 rtl/parallel_port_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/parallel_port_pkg.sv
// Shared definitions for the parallel port controller: register map, control/status
// bit positions and the sequencer state encoding.
package parallel_port_pkg;

  localparam logic [2:0] REG_DIR      = 3'd0;
  localparam logic [2:0] REG_DATA     = 3'd1;
  localparam logic [2:0] REG_SET      = 3'd2;
  localparam logic [2:0] REG_CLR      = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;
  localparam logic [2:0] REG_PRESCALE = 3'd5;
  localparam logic [2:0] REG_LIMIT    = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_DONE  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/parallel_port_ctrl_prescaler.sv
// Programmable rate generator: a down-counter that fires one tick when it reaches zero
// and reloads on every tick or on an explicit load request.
module parallel_port_prescaler #(
  parameter int PRESCALE_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] reload,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_r;

  assign tick = enable & (count_r == {PRESCALE_W{1'b0}});

  // Down-counter with reload on load request or tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {PRESCALE_W{1'b0}};
    end else if (load | tick) begin
      count_r <= reload;
    end else if (enable) begin
      count_r <= count_r - PRESCALE_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/parallel_port_ctrl.sv
// Avalon-MM slave owning the bidirectional parallel port: register file, pin synchroniser,
// and a counter sequencer that steps DATA toward LIMIT at the prescaled rate.
module parallel_port_ctrl
  import parallel_port_pkg::*;
#(
  parameter int PORT_W     = 8,
  parameter int PRESCALE_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic              irq,
  inout  wire  [PORT_W-1:0] ParPort
);

  state_e                state_r, state_n;
  logic [PORT_W-1:0]     dir_r, data_r, data_n, limit_r, sync1_r, sync2_r;
  logic [2:0]            ctrl_r, ctrl_n;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  done_r, done_n;
  logic                  wr_s, rd_s, ctrl_wr_s, data_wr_s, stop_s, status_clr_s;
  logic                  tick_s, step_s, at_limit_s, start_s, load_s, finish_s;
  logic [31:0]           rd_mux_s;

  assign wr_s         = chipselect & write;
  assign rd_s         = chipselect & read;
  assign ctrl_wr_s    = wr_s & (address == REG_CTRL);
  assign data_wr_s    = wr_s & ((address == REG_DATA) | (address == REG_SET) | (address == REG_CLR));
  assign stop_s       = ctrl_wr_s & ~writedata[CTRL_RUN];
  assign status_clr_s = wr_s & (address == REG_STATUS) & writedata[STATUS_DONE];
  assign at_limit_s   = (data_r == limit_r);
  // Any CPU write to DATA/SET/CLR or CTRL pre-empts the sequencer step of that cycle
  assign step_s       = (state_r == RUN) & tick_s & ~ctrl_wr_s & ~data_wr_s;
  assign finish_s     = step_s & at_limit_s & ctrl_r[CTRL_ONESHOT];
  assign start_s      = (state_r != RUN) & (state_n == RUN);
  assign load_s       = start_s | ((state_r == RUN) & (state_n == IDLE));

  parallel_port_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .enable (state_r == RUN),
    .reload (prescale_r),
    .tick   (tick_s)
  );

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (ctrl_wr_s & writedata[CTRL_RUN]) state_n = RUN;
        else state_n = IDLE;
      end
      RUN: begin
        if (stop_s) state_n = IDLE;
        else if (finish_s) state_n = DONE;
        else state_n = RUN;
      end
      DONE: begin
        if (ctrl_wr_s & writedata[CTRL_RUN]) state_n = RUN;
        else if (status_clr_s) state_n = IDLE;
        else state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequencer outputs: next DATA, done flag and CTRL
  always_comb begin
    data_n = data_r;
    done_n = done_r;
    ctrl_n = ctrl_r;
    if (wr_s & (address == REG_DATA)) data_n = writedata[PORT_W-1:0];
    else if (wr_s & (address == REG_SET)) data_n = data_r | writedata[PORT_W-1:0];
    else if (wr_s & (address == REG_CLR)) data_n = data_r & ~writedata[PORT_W-1:0];
    else if (step_s & at_limit_s) data_n = ctrl_r[CTRL_ONESHOT] ? data_r : {PORT_W{1'b0}};
    else if (step_s) data_n = data_r + PORT_W'(1);
    else data_n = data_r;
    // A done-set in the same cycle as a clear takes priority
    if (step_s & at_limit_s) done_n = 1'b1;
    else if (start_s | status_clr_s) done_n = 1'b0;
    else done_n = done_r;
    if (ctrl_wr_s) ctrl_n = writedata[2:0];
    else if (finish_s) ctrl_n = ctrl_r & 3'b110;
    else ctrl_n = ctrl_r;
  end

  // Register file, interrupt and pin synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_r      <= {PORT_W{1'b0}};
      data_r     <= {PORT_W{1'b0}};
      ctrl_r     <= 3'b000;
      prescale_r <= {PRESCALE_W{1'b0}};
      limit_r    <= {PORT_W{1'b1}};
      done_r     <= 1'b0;
      irq        <= 1'b0;
      sync1_r    <= {PORT_W{1'b0}};
      sync2_r    <= {PORT_W{1'b0}};
    end else begin
      dir_r      <= (wr_s & (address == REG_DIR)) ? writedata[PORT_W-1:0] : dir_r;
      prescale_r <= (wr_s & (address == REG_PRESCALE)) ? writedata[PRESCALE_W-1:0] : prescale_r;
      limit_r    <= (wr_s & (address == REG_LIMIT)) ? writedata[PORT_W-1:0] : limit_r;
      data_r     <= data_n;
      ctrl_r     <= ctrl_n;
      done_r     <= done_n;
      irq        <= done_n & ctrl_n[CTRL_IRQ_EN];
      sync1_r    <= ParPort;
      sync2_r    <= sync1_r;
    end
  end

  // Read multiplexer; DATA reads return the synchronised pins
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      REG_DIR:      rd_mux_s = 32'(dir_r);
      REG_DATA:     rd_mux_s = 32'(sync2_r);
      REG_CTRL:     rd_mux_s = 32'(ctrl_r);
      REG_PRESCALE: rd_mux_s = 32'(prescale_r);
      REG_LIMIT:    rd_mux_s = 32'(limit_r);
      REG_STATUS:   rd_mux_s = {30'd0, done_r, (state_r == RUN)};
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Read data register, one cycle latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (rd_s) begin
      readdata <= rd_mux_s;
    end else begin
      readdata <= readdata;
    end
  end

  for (genvar i = 0; i < PORT_W; i++) begin : g_pins
    assign ParPort[i] = dir_r[i] ? data_r[i] : 1'bz;
  end

endmodule
